// File: rtl/led_rx_deser_pkg.sv
// Shared types and widths for the LED link receive deserializer.
package led_pkg;
    localparam int COMP_W = 4;
    localparam int PIX_W  = 12;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_IDLE,
        DISCARD
    } rx_state_t;
endpackage

// File: rtl/led_rx_deser_if.sv
// Received-frame bus: per-lane RGB words, event strobes and the good-frame counter.
interface led_rx_deser_if #(
    parameter int LANES = 8
);
    logic [LANES-1:0][led_pkg::COMP_W-1:0] rx_R;
    logic [LANES-1:0][led_pkg::COMP_W-1:0] rx_G;
    logic [LANES-1:0][led_pkg::COMP_W-1:0] rx_B;
    logic                                  frame_vld;
    logic                                  trunc_err;
    logic                                  ovr_err;
    logic [15:0]                           frame_cnt;

    modport master (
        output rx_R, rx_G, rx_B, frame_vld, trunc_err, ovr_err, frame_cnt
    );
    modport slave (
        input  rx_R, rx_G, rx_B, frame_vld, trunc_err, ovr_err, frame_cnt
    );
endinterface

// File: rtl/led_rx_deser_sync.sv
// Synchronizer chain for the asynchronous link inputs plus a cko rising-edge detector.
module led_rx_sync #(
    parameter int LANES       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_fast,
    input  logic             rstn,
    input  logic             cko_i,
    input  logic [LANES-1:0] sdo_i,
    output logic             cko_rise_o,
    output logic [LANES-1:0] sdo_o
);
    logic [SYNC_STAGES-1:0][LANES:0] sync_q;
    logic                            cko_prev_q;

    always_ff @(posedge clk_fast or negedge rstn) begin
        if (!rstn) begin
            sync_q     <= '0;
            cko_prev_q <= 1'b0;
        end else begin
            sync_q[0] <= {cko_i, sdo_i};
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            cko_prev_q <= sync_q[SYNC_STAGES-1][LANES];
        end
    end

    assign cko_rise_o = sync_q[SYNC_STAGES-1][LANES] & ~cko_prev_q;
    assign sdo_o      = sync_q[SYNC_STAGES-1][LANES-1:0];
endmodule

// File: rtl/led_rx_deser.sv
// LED link receiver: shifts synced sdo lanes on cko edges and frames pixels on cko idle gaps.
module led_rx_deser
    import led_pkg::*;
#(
    parameter int LANES       = 8,
    parameter int BITS        = PIX_W,
    parameter int IDLE_CYC    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_fast,
    input  logic             rstn,
    input  logic             en,
    input  logic             cko_i,
    input  logic [LANES-1:0] sdo_i,
    led_rx_deser_if.master   rx
);
    localparam int CNT_W = $clog2(IDLE_CYC + 1);
    localparam int BIT_W = $clog2(BITS + 1);

    logic                             cko_rise;
    logic [LANES-1:0]                 sdo_s;
    logic [CNT_W-1:0]                 idle_cnt_q;
    logic                             gap;
    logic [LANES-1:0][BITS-1:0]       sh_q;
    logic [LANES-1:0][BITS-1:0]       sh_d;
    rx_state_t                        state_q;
    logic [BIT_W-1:0]                 bit_cnt_q;
    logic [LANES-1:0][COMP_W-1:0]     rx_R_q, rx_G_q, rx_B_q;
    logic                             frame_vld_q, trunc_err_q, ovr_err_q;
    logic [15:0]                      frame_cnt_q;

    led_rx_sync #(
        .LANES      (LANES),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_fast  (clk_fast),
        .rstn      (rstn),
        .cko_i     (cko_i),
        .sdo_i     (sdo_i),
        .cko_rise_o(cko_rise),
        .sdo_o     (sdo_s)
    );

    always_comb begin
        sh_d = sh_q;
        for (int unsigned i = 0; i < LANES; i++) begin
            sh_d[i] = {sh_q[i][BITS-2:0], sdo_s[i]};
        end
    end

    assign gap = (idle_cnt_q == CNT_W'(IDLE_CYC - 1)) && !cko_rise;

    always_ff @(posedge clk_fast or negedge rstn) begin
        if (!rstn) begin
            idle_cnt_q <= CNT_W'(IDLE_CYC);
            sh_q       <= '0;
        end else begin
            if (cko_rise) begin
                idle_cnt_q <= '0;
                sh_q       <= sh_d;
            end else if (idle_cnt_q != CNT_W'(IDLE_CYC)) begin
                idle_cnt_q <= idle_cnt_q + CNT_W'(1);
            end
        end
    end

    // Frame capture uses sh_d so the BITS-th bit lands in the same cycle it is seen.
    always_ff @(posedge clk_fast or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_R_q      <= '0;
            rx_G_q      <= '0;
            rx_B_q      <= '0;
            frame_vld_q <= 1'b0;
            trunc_err_q <= 1'b0;
            ovr_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            frame_vld_q <= 1'b0;
            trunc_err_q <= 1'b0;
            ovr_err_q   <= 1'b0;
            if (!en) begin
                state_q   <= IDLE;
                bit_cnt_q <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (cko_rise) begin
                            bit_cnt_q <= BIT_W'(1);
                            state_q   <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (cko_rise) begin
                            if (bit_cnt_q == BIT_W'(BITS - 1)) begin
                                for (int unsigned i = 0; i < LANES; i++) begin
                                    rx_R_q[i] <= sh_d[i][BITS-1 -: COMP_W];
                                    rx_G_q[i] <= sh_d[i][BITS-1-COMP_W -: COMP_W];
                                    rx_B_q[i] <= sh_d[i][COMP_W-1:0];
                                end
                                frame_vld_q <= 1'b1;
                                frame_cnt_q <= frame_cnt_q + 16'd1;
                                bit_cnt_q   <= BIT_W'(BITS);
                                state_q     <= WAIT_IDLE;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                            end
                        end else if (gap) begin
                            trunc_err_q <= 1'b1;
                            bit_cnt_q   <= '0;
                            state_q     <= IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        if (cko_rise) begin
                            ovr_err_q <= 1'b1;
                            state_q   <= DISCARD;
                        end else if (gap) begin
                            bit_cnt_q <= '0;
                            state_q   <= IDLE;
                        end
                    end
                    DISCARD: begin
                        if (gap) begin
                            bit_cnt_q <= '0;
                            state_q   <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign rx.rx_R      = rx_R_q;
    assign rx.rx_G      = rx_G_q;
    assign rx.rx_B      = rx_B_q;
    assign rx.frame_vld = frame_vld_q;
    assign rx.trunc_err = trunc_err_q;
    assign rx.ovr_err   = ovr_err_q;
    assign rx.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_led_rx_deser.sv
// Self-checking bench for led_rx_deser: directed vector table, corner sequences, random bursts.
module tb_led_rx_deser;
    localparam int LANES       = 8;
    localparam int BITS        = 12;
    localparam int IDLE_CYC    = 16;
    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 1;

    typedef logic [LANES-1:0][BITS-1:0] frame_t;

    typedef struct {
        int          nbits;
        logic [11:0] base;
        logic [11:0] step;
        int          gap;
        int          ev;
        int          et;
        int          eo;
    } vec_t;

    logic             clk_fast = 1'b0;
    logic             rstn     = 1'b0;
    logic             en       = 1'b0;
    logic             cko_i    = 1'b0;
    logic [LANES-1:0] sdo_i    = '0;

    led_rx_deser_if #(.LANES(LANES)) rx_if ();

    led_rx_deser #(
        .LANES      (LANES),
        .BITS       (BITS),
        .IDLE_CYC   (IDLE_CYC),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk_fast(clk_fast),
        .rstn    (rstn),
        .en      (en),
        .cko_i   (cko_i),
        .sdo_i   (sdo_i),
        .rx      (rx_if)
    );

    always #2 clk_fast = ~clk_fast;

    int cyc = 0;
    always @(posedge clk_fast) cyc <= cyc + 1;

    int n_vld = 0, n_trunc = 0, n_ovr = 0, n_excl = 0;
    int t_vld = 0, t_trunc = 0, t_ovr = 0;
    always @(negedge clk_fast) begin
        if (rstn) begin
            if (rx_if.frame_vld) begin n_vld++;   t_vld   = cyc; end
            if (rx_if.trunc_err) begin n_trunc++; t_trunc = cyc; end
            if (rx_if.ovr_err)   begin n_ovr++;   t_ovr   = cyc; end
            if (int'(rx_if.frame_vld) + int'(rx_if.trunc_err) + int'(rx_if.ovr_err) > 1) n_excl++;
        end
    end

    int checks = 0, failures = 0;
    frame_t      m_rx = '0;
    logic [15:0] m_cnt = '0;
    int          rise_cyc [32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_frame(input string tag);
        logic [LANES-1:0][3:0] eR, eG, eB;
        for (int i = 0; i < LANES; i++) begin
            eR[i] = m_rx[i][11:8];
            eG[i] = m_rx[i][7:4];
            eB[i] = m_rx[i][3:0];
        end
        chk({tag, "_rxR"}, 64'(rx_if.rx_R), 64'(eR));
        chk({tag, "_rxG"}, 64'(rx_if.rx_G), 64'(eG));
        chk({tag, "_rxB"}, 64'(rx_if.rx_B), 64'(eB));
        chk({tag, "_cnt"}, 64'(rx_if.frame_cnt), 64'(m_cnt));
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_fast);
    endtask

    // Each bit: data set with cko low for 3 cycles, then cko high for 3 cycles.
    task automatic send_burst(input frame_t w, input int nbits, input int gap);
        logic [LANES-1:0] d;
        for (int k = 0; k < nbits; k++) begin
            for (int i = 0; i < LANES; i++)
                d[i] = (k < BITS) ? w[i][BITS-1-k] : 1'($urandom_range(0, 1));
            sdo_i = d;
            wait_cyc(3);
            cko_i = 1'b1;
            rise_cyc[k] = cyc;
            wait_cyc(3);
            cko_i = 1'b0;
        end
        wait_cyc(gap);
    endtask

    task automatic run_burst(input string tag, input frame_t w, input int nbits, input int gap,
                             input bit en_on, input int ev, input int et, input int eo);
        int v0, tr0, o0;
        v0 = n_vld; tr0 = n_trunc; o0 = n_ovr;
        en = en_on;
        send_burst(w, nbits, gap);
        chk({tag, "_vld"},   64'(n_vld - v0),   64'(ev));
        chk({tag, "_trunc"}, 64'(n_trunc - tr0), 64'(et));
        chk({tag, "_ovr"},   64'(n_ovr - o0),   64'(eo));
        chk({tag, "_excl"},  64'(n_excl),       64'd0);
        if (ev != 0) begin
            m_rx  = w;
            m_cnt = m_cnt + 16'd1;
            chk({tag, "_tvld"}, 64'(t_vld), 64'(rise_cyc[BITS-1] + LAT));
        end
        if (et != 0)
            chk({tag, "_ttrunc"}, 64'(t_trunc), 64'(rise_cyc[nbits-1] + LAT + IDLE_CYC));
        if (eo != 0)
            chk({tag, "_tovr"}, 64'(t_ovr), 64'(rise_cyc[(nbits > BITS) ? BITS : 0] + LAT));
        chk_frame(tag);
        en = 1'b1;
    endtask

    function automatic frame_t mk_frame(input logic [11:0] base, input logic [11:0] step);
        frame_t f;
        for (int i = 0; i < LANES; i++) f[i] = base + step * 12'(i);
        return f;
    endfunction

    vec_t tbl [11];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        frame_t w, w2;
        int     nb;
        bit     eon;

        tbl[0]  = '{12, 12'h111, 12'h111, 20,           1, 0, 0};
        tbl[1]  = '{7,  12'h0AB, 12'h013, 20,           0, 1, 0};
        tbl[2]  = '{14, 12'h123, 12'h111, 20,           1, 0, 1};
        tbl[3]  = '{12, 12'h5A5, 12'h001, 20,           1, 0, 0};
        tbl[4]  = '{12, 12'hFFF, 12'h000, IDLE_CYC - 5, 1, 0, 0};
        tbl[5]  = '{12, 12'h000, 12'h000, IDLE_CYC - 5, 1, 0, 0};
        tbl[6]  = '{12, 12'hA5A, 12'h000, 20,           1, 0, 0};
        tbl[7]  = '{12, 12'h3C3, 12'h010, IDLE_CYC - 6, 1, 0, 0};
        tbl[8]  = '{12, 12'h777, 12'h000, 20,           0, 0, 1};
        tbl[9]  = '{1,  12'h800, 12'h000, 20,           0, 1, 0};
        tbl[10] = '{11, 12'h9E1, 12'h105, 20,           0, 1, 0};

        wait_cyc(5);
        chk_frame("reset");
        chk("reset_vld",   64'(rx_if.frame_vld), 64'd0);
        chk("reset_trunc", 64'(rx_if.trunc_err), 64'd0);
        chk("reset_ovr",   64'(rx_if.ovr_err),   64'd0);
        rstn = 1'b1;
        en   = 1'b1;
        wait_cyc(5);

        for (int t = 0; t < 11; t++) begin
            run_burst($sformatf("vec%0d", t), mk_frame(tbl[t].base, tbl[t].step),
                      tbl[t].nbits, tbl[t].gap, 1'b1, tbl[t].ev, tbl[t].et, tbl[t].eo);
            if (t == 0) begin
                chk("good_R7",  64'(rx_if.rx_R[7]),   64'd8);
                chk("good_B0",  64'(rx_if.rx_B[0]),   64'd1);
                chk("good_cnt", 64'(rx_if.frame_cnt), 64'd1);
            end
            if (t == 6) chk("b2b_cnt", 64'(rx_if.frame_cnt), 64'd6);
        end

        // Enable dropped mid-frame: partial frame vanishes silently.
        w  = mk_frame(12'h2D4, 12'h0F1);
        w2 = mk_frame(12'hC18, 12'h233);
        run_burst("abort_part", w, 5, 3, 1'b1, 0, 0, 0);
        en = 1'b0;
        wait_cyc(25);
        en = 1'b1;
        wait_cyc(2);
        run_burst("abort_new", w2, 12, 20, 1'b1, 1, 0, 0);

        // Reset mid-frame returns everything to reset values with no pulses.
        send_burst(mk_frame(12'h6B1, 12'h011), 6, 3);
        rstn = 1'b0;
        wait_cyc(1);
        m_rx  = '0;
        m_cnt = '0;
        chk_frame("rstmid");
        chk("rstmid_vld", 64'({rx_if.frame_vld, rx_if.trunc_err, rx_if.ovr_err}), 64'd0);
        wait_cyc(3);
        rstn = 1'b1;
        run_burst("rstmid_after", '0, 0, 30, 1'b1, 0, 0, 0);

        // Counter wrap.
        force dut.frame_cnt_q = 16'hFFFF;
        wait_cyc(1);
        release dut.frame_cnt_q;
        wait_cyc(1);
        m_cnt = 16'hFFFF;
        chk("wrap_pre", 64'(rx_if.frame_cnt), 64'hFFFF);
        run_burst("wrap", mk_frame(12'h159, 12'h0A0), 12, 20, 1'b1, 1, 0, 0);
        chk("wrap_zero", 64'(rx_if.frame_cnt), 64'd0);

        // Random bursts against the burst-length rules.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < LANES; i++) w[i] = 12'($urandom);
            nb  = $urandom_range(0, 15);
            eon = ($urandom_range(0, 7) != 0);
            run_burst($sformatf("rnd%0d", r), w, nb, $urandom_range(20, 30), eon,
                      (eon && nb >= BITS) ? 1 : 0,
                      (eon && nb >= 1 && nb < BITS) ? 1 : 0,
                      (eon && nb > BITS) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
